// File: rtl/div_seq_pkg.sv
// Shared encodings for the EX-stage sequential divider.
// FSM states, result-ready flags, start/stop levels and sign selector.
package div_seq_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivSigned         = 1'b1;
    localparam logic DivUnsigned       = 1'b0;

    function automatic logic [DIV_W-1:0] mag(
        input logic [DIV_W-1:0] v,
        input logic             sgn
    );
        return (sgn && v[DIV_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_seq.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Define DIV_EARLY_EXIT_EN to finish at once when |dividend| < |divisor|.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    div_state_t         state, state_n;
    logic [5:0]         cnt;
    logic [2*DIV_W:0]   work, work_n;
    logic [DIV_W-1:0]   dvsr;
    logic               neg_q, neg_r;
    logic [DIV_W-1:0]   abs1, abs2;
    logic [DIV_W:0]     trial;
    logic [DIV_W-1:0]   quo, rem;
    logic               early;

    assign abs1 = mag(opdata1_i, signed_div_i);
    assign abs2 = mag(opdata2_i, signed_div_i);

`ifdef DIV_EARLY_EXIT_EN
    assign early = (abs1 < abs2);
`else
    assign early = 1'b0;
`endif

    assign trial  = work[2*DIV_W:DIV_W] - {1'b0, dvsr};
    assign work_n = trial[DIV_W]
                  ? {work[2*DIV_W-1:0], 1'b0}
                  : {trial[DIV_W-1:0], work[DIV_W-1:0], 1'b1};
    assign quo = neg_q ? (~work_n[DIV_W-1:0] + 1'b1)
                       : work_n[DIV_W-1:0];
    assign rem = neg_r ? (~work_n[2*DIV_W:DIV_W+1] + 1'b1)
                       : work_n[2*DIV_W:DIV_W+1];

    always_comb begin
        state_n = state;
        unique case (state)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0)
                        state_n = DivByZero;
                    else if (early)
                        state_n = DivEnd;
                    else
                        state_n = DivOn;
                end
            end
            DivByZero: state_n = annul_i ? DivFree : DivEnd;
            DivOn: begin
                if (annul_i)
                    state_n = DivFree;
                else if (cnt == 6'd31)
                    state_n = DivEnd;
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop)
                    state_n = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= DivFree;
            cnt      <= '0;
            work     <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                DivFree: begin
                    if (state_n == DivOn) begin
                        work  <= {{DIV_W{1'b0}}, abs1, 1'b0};
                        dvsr  <= abs2;
                        neg_q <= signed_div_i &
                                 (opdata1_i[DIV_W-1] ^ opdata2_i[DIV_W-1]);
                        neg_r <= signed_div_i & opdata1_i[DIV_W-1];
                        cnt   <= '0;
                    end else if (state_n == DivEnd) begin
                        result_o <= {opdata1_i, {DIV_W{1'b0}}};
                    end
                end
                DivByZero: result_o <= '0;
                DivOn: begin
                    if (annul_i) begin
                        cnt      <= '0;
                        result_o <= '0;
                    end else begin
                        work <= work_n;
                        cnt  <= cnt + 6'd1;
                        if (state_n == DivEnd)
                            result_o <= {rem, quo};
                    end
                end
                DivEnd: begin
                    if (state_n == DivFree) begin
                        result_o <= '0;
                        cnt      <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy_o  = (state != DivFree);
        ready_o = (state == DivEnd) ? DivResultReady : DivResultNotReady;
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq against an arithmetic reference.
// Directed cases from the plan followed by randomized operands.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    div_seq #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sgn,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    function automatic int ref_lat(input logic sgn,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb) return 33;
`endif
        return 33;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_div(input string tag, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp_res;
        int          exp_lat;
        int          n;
        exp_res = ref_div(sgn, a, b);
        exp_lat = ref_lat(sgn, a, b);
        signed_div_i = sgn;
        opdata1_i = a;
        opdata2_i = b;
        annul_i = 1'b0;
        start_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready_o && n < 40);
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_res"}, result_o, exp_res);
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~sgn;
        tick();
        chk({tag, "_hold"}, {ready_o, result_o[62:0]},
            {1'b1, exp_res[62:0]});
        start_i = 1'b0;
        tick();
        chk({tag, "_rel"}, {62'd0, ready_o, busy_o}, 64'd0);
        chk({tag, "_clr"}, result_o, 64'd0);
    endtask

    initial begin
        logic        s;
        logic [31:0] a, b;
        int          seen;
        rst = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();
        tick();
        chk("reset_out", {result_o[61:0], ready_o, busy_o}, 64'd0);
        chk("reset_res", result_o, 64'd0);
        rst = 1'b1;
        tick();

        do_div("divu_7_2", 1'b0, 32'd7, 32'd2);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_div("div_5_0", 1'b1, 32'd5, 32'd0);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("divu_3_10", 1'b0, 32'd3, 32'd10);
        do_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);

        // Annul part-way through the iterations
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (ready_o) seen++;
        end
        chk("annul_busy_pre", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        tick();
        chk("annul_busy", 64'(busy_o), 64'd0);
        if (ready_o) seen++;
        tick();
        chk("annul_stay", 64'(busy_o), 64'd0);
        if (ready_o) seen++;
        chk("annul_noready", 64'(seen), 64'd0);
        chk("annul_res", result_o, 64'd0);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3);

        // Reset mid-iteration, with annul also raised
        signed_div_i = 1'b1;
        opdata1_i = 32'h1234_5678;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b0;
        annul_i = 1'b1;
        tick();
        chk("rst_mid", {62'd0, ready_o, busy_o}, 64'd0);
        chk("rst_mid_res", result_o, 64'd0);
        rst = 1'b1;
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom_range(1, 15);
                1: b = 32'd0;
                2: a = $urandom_range(0, 99);
                3: b = -$urandom_range(1, 15);
                default: ;
            endcase
            do_div($sformatf("rnd%0d", i), s, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
